// File: rtl/nonce_arbiter.sv
// nonce_arbiter: round-robin collector for golden nonces from all sources.
// Captures, queues and feeds results to serial_transmit via send/busy.
module nonce_arbiter #(
  parameter int SLAVES     = 3,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                             uart_clk,
  input  logic                             reset_n,
  input  logic [SLAVES*32-1:0]             slave_nonces,
  input  logic [SLAVES-1:0]                new_nonces,
  input  logic                             flush,
  input  logic                             serial_busy,
  output logic                             serial_send,
  output logic [31:0]                      golden_nonce,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count,
  output logic [15:0]                      drop_count
);

  localparam int SW = (SLAVES > 1) ? $clog2(SLAVES) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int DW = $clog2(SLAVES + 1);

  localparam logic [AW:0]   PTR_ONE = 1;
  localparam logic [SW-1:0] PTR_RST = SW'(SLAVES - 1);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    TX
  } state_t;

  state_t state;
  state_t state_nx;

  logic [SLAVES-1:0] pend;
  logic [31:0]       hold [SLAVES];
  logic [SW-1:0]     rr_ptr;

  logic              found;
  logic [SW-1:0]     sel;
  logic [31:0]       gnt_data;
  logic              gnt;
  logic [SLAVES-1:0] gnt_vec;

  logic [DW-1:0]     drop_inc;
  logic [16:0]       drop_sum;

  logic [31:0]       mem [FIFO_DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;

  assign empty      = (wr_ptr == rd_ptr);
  assign full       = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign fifo_count = CW'(wr_ptr - rd_ptr);

  // RR search: first pending slave above the pointer, else wrap to the lowest.
  always_comb begin
    found    = 1'b0;
    sel      = '0;
    gnt_data = '0;
    for (int i = 0; i < SLAVES; i++) begin
      if (!found && pend[i] && (i > int'(rr_ptr))) begin
        found    = 1'b1;
        sel      = SW'(i);
        gnt_data = hold[i];
      end
    end
    for (int i = 0; i < SLAVES; i++) begin
      if (!found && pend[i] && (i <= int'(rr_ptr))) begin
        found    = 1'b1;
        sel      = SW'(i);
        gnt_data = hold[i];
      end
    end
  end

  // A flush-cycle grant would be thrown away, so it is not taken at all.
  assign gnt  = found && !full && !flush;
  assign push = gnt;

  // One-hot view of the grant for the per-slave flag logic.
  always_comb begin
    gnt_vec = '0;
    for (int i = 0; i < SLAVES; i++) begin
      gnt_vec[i] = gnt && (sel == SW'(i));
    end
  end

  // Count strobes that overwrite a still-pending, ungranted result.
  always_comb begin
    drop_inc = '0;
    for (int i = 0; i < SLAVES; i++) begin
      if (new_nonces[i] && pend[i] && !gnt_vec[i] && !flush) begin
        drop_inc = drop_inc + DW'(1);
      end
    end
  end

  assign drop_sum = {1'b0, drop_count} + 17'(drop_inc);

  // Saturating drop counter; flush leaves it alone.
  always_ff @(posedge uart_clk or negedge reset_n) begin
    if (!reset_n) begin
      drop_count <= '0;
    end else begin
      drop_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end

  // Holding registers load on every strobe, including a grant-cycle strobe.
  always_ff @(posedge uart_clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SLAVES; i++) begin
        hold[i] <= '0;
      end
    end else begin
      for (int i = 0; i < SLAVES; i++) begin
        if (new_nonces[i]) begin
          hold[i] <= slave_nonces[i*32 +: 32];
        end
      end
    end
  end

  // Pending flags: a strobe always wins, so same-cycle new work survives flush.
  always_ff @(posedge uart_clk or negedge reset_n) begin
    if (!reset_n) begin
      pend <= '0;
    end else begin
      for (int i = 0; i < SLAVES; i++) begin
        if (new_nonces[i]) begin
          pend[i] <= 1'b1;
        end else if (flush || gnt_vec[i]) begin
          pend[i] <= 1'b0;
        end
      end
    end
  end

  // RR pointer follows the last winner.
  always_ff @(posedge uart_clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr <= PTR_RST;
    end else if (gnt) begin
      rr_ptr <= sel;
    end
  end

  // Queue storage needs no reset; occupancy lives in the pointers.
  always_ff @(posedge uart_clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= gnt_data;
    end
  end

  // Queue pointers; flush empties the queue in a single cycle.
  always_ff @(posedge uart_clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Output FSM state register.
  always_ff @(posedge uart_clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Output FSM: pop in IDLE, request until busy, then wait for busy to drop.
  always_comb begin
    state_nx    = state;
    pop         = 1'b0;
    serial_send = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty && !flush) begin
          pop      = 1'b1;
          state_nx = REQ;
        end
      end
      REQ: begin
        serial_send = 1'b1;
        if (serial_busy) state_nx = TX;
      end
      TX: begin
        if (!serial_busy) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // The transmitted word changes only when a new request starts.
  always_ff @(posedge uart_clk or negedge reset_n) begin
    if (!reset_n) begin
      golden_nonce <= '0;
    end else if (pop) begin
      golden_nonce <= mem[rd_ptr[AW-1:0]];
    end
  end

endmodule

// File: tb/tb_nonce_arbiter.sv
// tb_nonce_arbiter: directed plus random checks of nonce_arbiter
// against a queue-based reference model of the result path.
module tb_nonce_arbiter;

  localparam int S = 3;
  localparam int D = 8;

  logic            uart_clk = 1'b0;
  logic            reset_n;
  logic [S*32-1:0] slave_nonces;
  logic [S-1:0]    new_nonces;
  logic            flush;
  logic            serial_busy;
  logic            serial_send;
  logic [31:0]     golden_nonce;
  logic [3:0]      fifo_count;
  logic [15:0]     drop_count;

  nonce_arbiter #(.SLAVES(S), .FIFO_DEPTH(D)) dut (
    .uart_clk     (uart_clk),
    .reset_n      (reset_n),
    .slave_nonces (slave_nonces),
    .new_nonces   (new_nonces),
    .flush        (flush),
    .serial_busy  (serial_busy),
    .serial_send  (serial_send),
    .golden_nonce (golden_nonce),
    .fifo_count   (fifo_count),
    .drop_count   (drop_count)
  );

  always #5 uart_clk = ~uart_clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // reference model: flags, holding values, queue, transmitter phase
  bit          m_pend [S];
  logic [31:0] m_hold [S];
  int          m_ptr;
  logic [31:0] m_q [$];
  int          m_phase;
  logic [31:0] m_gn;
  int          m_drops;

  // transmitter busy model
  bit b_busy;
  int b_wait;
  int b_len;
  int cfg_delay;
  int cfg_len;

  int          cyc = 0;
  int          last_rise;
  bit          prev_send;
  logic [31:0] sent [$];

  task automatic model_reset();
    for (int i = 0; i < S; i++) begin
      m_pend[i] = 0;
      m_hold[i] = '0;
    end
    m_ptr = S - 1;
    m_q.delete();
    m_phase = 0;
    m_gn = '0;
    m_drops = 0;
    b_busy = 0;
    b_wait = 0;
    b_len = 0;
    prev_send = 0;
  endtask

  function automatic bit any_pend();
    bit r = 0;
    for (int i = 0; i < S; i++) r |= m_pend[i];
    return r;
  endfunction

  task automatic step(input logic [S-1:0] nv, input logic [S*32-1:0] nz,
                      input bit fl);
    int  w;
    bit  pp;
    @(negedge uart_clk);
    chk("send", {31'b0, serial_send}, {31'b0, m_phase == 1});
    chk("golden", golden_nonce, m_gn);
    chk("count", {28'b0, fifo_count}, m_q.size());
    chk("drops", {16'b0, drop_count}, m_drops);
    if (serial_send && !prev_send) begin
      sent.push_back(golden_nonce);
      last_rise = cyc;
    end
    prev_send = serial_send;
    if (b_busy) begin
      b_len--;
      if (b_len <= 0) b_busy = 0;
    end else if (m_phase == 1) begin
      if (b_wait == 0) begin
        b_wait = cfg_delay;
      end else begin
        b_wait--;
        if (b_wait == 0) begin
          b_busy = 1;
          b_len = cfg_len;
        end
      end
    end
    new_nonces   = nv;
    slave_nonces = nz;
    flush        = fl;
    serial_busy  = b_busy;
    w = -1;
    if (!fl && m_q.size() < D) begin
      for (int k = 1; k <= S; k++) begin
        int j;
        j = (m_ptr + k) % S;
        if (w < 0 && m_pend[j]) w = j;
      end
    end
    pp = (m_phase == 0) && (m_q.size() > 0) && !fl;
    if (fl) begin
      m_q.delete();
    end else begin
      if (pp) m_gn = m_q.pop_front();
      if (w >= 0) m_q.push_back(m_hold[w]);
    end
    case (m_phase)
      0: if (pp) m_phase = 1;
      1: if (b_busy) m_phase = 2;
      default: if (!b_busy) m_phase = 0;
    endcase
    for (int i = 0; i < S; i++) begin
      if (nv[i]) begin
        if (m_pend[i] && w != i && !fl && m_drops < 65535) m_drops++;
        m_hold[i] = nz[i*32 +: 32];
        m_pend[i] = 1;
      end else if (fl || w == i) begin
        m_pend[i] = 0;
      end
    end
    if (w >= 0) m_ptr = w;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0, '0, 0);
  endtask

  task automatic strobe(input int s, input logic [31:0] v, input bit fl);
    logic [S-1:0]    nv;
    logic [S*32-1:0] nz;
    nv = '0;
    nz = '0;
    nv[s] = 1'b1;
    nz[s*32 +: 32] = v;
    step(nv, nz, fl);
  endtask

  task automatic drain(input int lim);
    int n;
    n = 0;
    while ((m_q.size() > 0 || any_pend() || m_phase != 0 || b_busy)
           && n < lim) begin
      step('0, '0, 0);
      n++;
    end
    idle(2);
    chk("drain_bound", {31'b0, n < lim}, 32'd1);
  endtask

  task automatic do_reset();
    @(negedge uart_clk);
    reset_n = 0;
    new_nonces = '0;
    flush = 0;
    serial_busy = 0;
    #1;
    chk("rst_send", {31'b0, serial_send}, 32'd0);
    chk("rst_golden", golden_nonce, 32'd0);
    chk("rst_count", {28'b0, fifo_count}, 32'd0);
    chk("rst_drops", {16'b0, drop_count}, 32'd0);
    model_reset();
    sent.delete();
    @(negedge uart_clk);
    reset_n = 1;
  endtask

  task automatic chk_sent(input string tag, input int i,
                          input logic [31:0] exp);
    logic [31:0] got;
    got = (i < sent.size()) ? sent[i] : 32'hBAD0_BAD0;
    chk(tag, got, exp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t;
    int n;
    reset_n = 0;
    new_nonces = '0;
    slave_nonces = '0;
    flush = 0;
    serial_busy = 0;
    cfg_delay = 1;
    cfg_len = 40;
    last_rise = -100;
    model_reset();
    repeat (3) @(negedge uart_clk);
    reset_n = 1;

    // single result, latency and single send
    idle(2);
    t = cyc;
    strobe(1, 32'hDEADBEEF, 0);
    idle(5);
    chk("t1_latency", last_rise - t, 32'd3);
    drain(300);
    chk("t1_nsent", sent.size(), 32'd1);
    chk_sent("t1_word", 0, 32'hDEADBEEF);
    chk("t1_drop", {16'b0, drop_count}, 32'd0);

    // round robin, simultaneous strobes
    cfg_len = 10;
    do_reset();
    step(3'b111, {32'h12, 32'h11, 32'h10}, 0);
    drain(300);
    chk("rr_n", sent.size(), 32'd3);
    chk_sent("rr0", 0, 32'h10);
    chk_sent("rr1", 1, 32'h11);
    chk_sent("rr2", 2, 32'h12);

    // slave 0 restrobed right after its grant
    do_reset();
    step(3'b111, {32'h12, 32'h11, 32'h10}, 0);
    idle(1);
    strobe(0, 32'h20, 0);
    drain(300);
    chk("rrb_n", sent.size(), 32'd4);
    chk_sent("rrb1", 1, 32'h11);
    chk_sent("rrb2", 2, 32'h12);
    chk_sent("rrb3", 3, 32'h20);

    // slave 0 restrobed in its grant cycle: no drop
    do_reset();
    step(3'b111, {32'h12, 32'h11, 32'h10}, 0);
    strobe(0, 32'h30, 0);
    drain(300);
    chk_sent("rrc0", 0, 32'h10);
    chk_sent("rrc3", 3, 32'h30);
    chk("rrc_drop", {16'b0, drop_count}, 32'd0);

    // overwrite while the queue is full
    cfg_len = 150;
    do_reset();
    for (int k = 0; k < 9; k++) strobe(k % 2, 32'h100 + k, 0);
    idle(3);
    chk("ovw_full", {28'b0, fifo_count}, 32'd8);
    strobe(2, 32'hA, 0);
    idle(1);
    strobe(2, 32'hB, 0);
    idle(2);
    chk("ovw_drop", {16'b0, drop_count}, 32'd1);
    if (b_busy) b_len = 2;
    cfg_len = 5;
    drain(1000);
    chk("ovw_n", sent.size(), 32'd10);
    chk_sent("ovw_first", 0, 32'h100);
    chk_sent("ovw_last", 9, 32'hB);

    // backpressure: 8 queued + 3 pending, no drops, order kept
    cfg_len = 300;
    do_reset();
    strobe(0, 32'h200, 0);
    idle(5);
    for (int k = 0; k < 11; k++) strobe(k % 3, 32'h300 + k, 0);
    idle(3);
    chk("bp_count", {28'b0, fifo_count}, 32'd8);
    chk("bp_drop", {16'b0, drop_count}, 32'd0);
    if (b_busy) b_len = 2;
    cfg_len = 4;
    drain(1000);
    chk("bp_n", sent.size(), 32'd12);
    chk_sent("bp_0", 0, 32'h200);
    for (int k = 0; k < 11; k++) chk_sent("bp_k", k + 1, 32'h300 + k);

    // flush mid-transmission with simultaneous new work
    cfg_len = 30;
    do_reset();
    for (int k = 0; k < 5; k++) strobe(k % 3, 32'h400 + k, 0);
    idle(8);
    strobe(0, 32'h55, 1);
    @(posedge uart_clk);
    #1;
    chk("fl_count", {28'b0, fifo_count}, 32'd0);
    drain(500);
    chk("fl_n", sent.size(), 32'd2);
    chk_sent("fl_0", 0, 32'h400);
    chk_sent("fl_1", 1, 32'h55);

    // asynchronous reset while requesting with queued words
    cfg_delay = 4;
    cfg_len = 20;
    for (int k = 0; k < 3; k++) strobe(k, 32'h600 + k, 0);
    n = 0;
    while (m_phase != 1 && n < 20) begin
      idle(1);
      n++;
    end
    chk("rst_reach_req", {31'b0, n < 20}, 32'd1);
    @(posedge uart_clk);
    #2;
    chk("pre_rst_send", {31'b0, serial_send}, 32'd1);
    reset_n = 0;
    #1;
    chk("mid_rst_send", {31'b0, serial_send}, 32'd0);
    chk("mid_rst_golden", golden_nonce, 32'd0);
    chk("mid_rst_count", {28'b0, fifo_count}, 32'd0);
    chk("mid_rst_drops", {16'b0, drop_count}, 32'd0);
    model_reset();
    sent.delete();
    new_nonces = '0;
    flush = 0;
    serial_busy = 0;
    @(negedge uart_clk);
    reset_n = 1;
    cfg_delay = 1;
    t = cyc;
    strobe(2, 32'h777, 0);
    idle(5);
    chk("rst_latency", last_rise - t, 32'd3);
    drain(300);
    chk_sent("rst_word", 0, 32'h777);

    // random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      logic [S-1:0]    nv;
      logic [S*32-1:0] nz;
      cfg_delay = $urandom_range(1, 3);
      cfg_len = $urandom_range(2, 30);
      for (int i = 0; i < S; i++) begin
        nv[i] = ($urandom_range(0, 7) == 0);
        nz[i*32 +: 32] = $urandom;
      end
      step(nv, nz, $urandom_range(0, 149) == 0);
    end
    drain(2000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nonce_arbiter.md
# nonce_arbiter

Collects golden-nonce results from all local miners and external-port receivers, queues them, and drives the shared `serial_transmit` instance with a send/busy handshake. It sits in the `uart_clk` domain, downstream of the per-miner clock-crossing toggles and `slave_receive` instances. It replaces a fixed-priority hub with round-robin arbitration, buffering, stale-work flushing and drop accounting.

## Interface
- `SLAVES`, 3, number of nonce sources (local miners + external ports), 1..16
- `FIFO_DEPTH`, 8, result queue depth, power of two, 2..64
- `uart_clk`  in  1  sole clock; all logic rises on it
- `reset_n`  in  1  asynchronous, active-low reset
- `slave_nonces`  in  SLAVES*32  nonce from slave i at bits [i*32+31:i*32], valid in the cycle its strobe is high
- `new_nonces`  in  SLAVES  per-slave single-cycle result strobes
- `flush`  in  1  single-cycle pulse (driven from `rx_done`): discard all queued results from stale work
- `serial_busy`  in  1  busy from `serial_transmit`
- `serial_send`  out  1  send request to `serial_transmit`
- `golden_nonce`  out  32  word being transmitted; stable while `serial_send` or `serial_busy` is high
- `fifo_count`  out  $clog2(FIFO_DEPTH+1)  current queue occupancy
- `drop_count`  out  16  saturating count of results lost to overwrite

## Operation
- Reset values: `serial_send`=0, `golden_nonce`=0, `fifo_count`=0, `drop_count`=0; all pending flags clear; RR pointer = SLAVES-1; FSM in IDLE.
- Capture stage: per slave, one pending flag + 32-bit holding register. Strobe high: register loads nonce, flag sets.
- Strobe on a slave whose flag is already set and not granted this cycle: newer nonce overwrites, `drop_count` increments (saturates at 16'hFFFF).
- Strobe arriving in the same cycle the slave is granted: grant takes old value, new value loads, flag stays set, no drop.
- Arbiter: each cycle with FIFO not full, grants the first set flag searching from (pointer+1) mod SLAVES upward with wrap; the winner is pushed into the FIFO, its flag cleared, pointer set to the winner. At most one grant per cycle. FIFO full: no grant, flags hold, nothing lost.
- FIFO: circular buffer, pointers wrap at FIFO_DEPTH, one extra bit distinguishes full/empty. Simultaneous push and pop leaves count unchanged.
- Output FSM:
  - IDLE: FIFO non-empty -> pop head into `golden_nonce`, assert `serial_send`, go REQ.
  - REQ: hold `serial_send` until `serial_busy`=1, then deassert, go TX.
  - TX: wait `serial_busy`=0, go IDLE.
- Flush: clears FIFO (count 0) and all pending flags in one cycle; strobes in the same cycle as flush are captured (new work). The in-flight word (REQ/TX) is not aborted. A grant in the flush cycle is discarded. `drop_count` is not cleared by flush.
- Reset mid-operation: everything returns to reset values immediately; an in-progress UART frame is the transmitter's concern.

## Timing
- Strobe in cycle t, empty FIFO, FSM IDLE: flag set at edge t+1, FIFO push at edge t+2, `serial_send` high from cycle t+3.
- `serial_send` is never high while FSM is in TX; back-to-back words are separated by at least one IDLE cycle after busy falls.
- `golden_nonce` changes only on the IDLE->REQ transition.
- With all SLAVES flags set and FIFO space available, all are queued within SLAVES cycles, in RR order.
- Throughput is bounded by the transmitter (one word per 4-byte frame); the queue absorbs bursts up to FIFO_DEPTH + SLAVES results with zero drops.

## Test plan
- Single result: strobe slave 1 with 32'hDEADBEEF, busy model rises 1 cycle after send and stays high 40 cycles -> `serial_send` high in cycle t+3, `golden_nonce`=32'hDEADBEEF, exactly one send, `drop_count`=0.
- Round-robin: strobe slaves 0,1,2 in the same cycle with 0x10,0x11,0x12 -> transmitted order 0x10,0x11,0x12; repeat with slave 0 strobed again just after its grant -> order is 0x11,0x12 then new slave 0 value.
- Overwrite: strobe slave 2 twice (0xA then 0xB) while FIFO is full -> only 0xB sent, `drop_count`=1.
- Backpressure: hold `serial_busy` high, inject 8 results (FIFO_DEPTH=8) plus 3 more -> `fifo_count`=8, 3 flags pending, no drops; release busy -> all 11 sent in order.
- Flush: queue 5 results, mid-transmission of the first pulse `flush` with a simultaneous strobe 0x55 -> first word completes, remaining 4 discarded, 0x55 sent next, `fifo_count` returns to 0.
- Reset: assert `reset_n`=0 during REQ with FIFO occupied -> all outputs zero immediately; after release a new strobe is sent with t+3 latency.
